rr_arbiter_8: RTL
=================

// Module: rr_arbiter_8
// PURPOSE
//  Round-robin arbiter that shares one resource between 8 requesters.
//  The 3-bit index it issues is consumed by downstream mux/select logic.
//  It sits in front of the encoder-based select path: rotated-priority
//  encoding, plus a registered grant, hold/release handshake and hold timeout.
// PARAMETERS
//  N         8   number of requesters; fixed at 8 (checked by elaboration assert)
//  IDXW      3   index width, clog2(N)
//  HOLD_MAX  16  max cycles a grant is held before forced release; 0 = no limit
// PORTS
//  clk        in   1     rising-edge clock
//  rst        in   1     asynchronous, active-high reset
//  req        in   8     request vector, bit i = requester i, level-sensitive
//  done       in   1     granted requester releases resource (single-cycle pulse)
//  gnt        out  8     one-hot grant, registered
//  gnt_idx    out  3     binary index of granted requester, registered
//  gnt_valid  out  1     high while a grant is active
//  timeout    out  1     1-cycle pulse when a grant is forcibly released
// BEHAVIOUR
//  Reset (async, immediate): gnt=0, gnt_idx=0, gnt_valid=0, timeout=0,
//   ptr=0, hold_cnt=0, state=IDLE.
//  State machine: IDLE, GRANT.
//  IDLE:
//   - If req!=0: pick the first set bit at or above ptr, scanning
//     ptr, ptr+1, ..., 7, 0, ..., ptr-1.
//   - Register gnt, gnt_idx and gnt_valid=1; go to GRANT.
//   - Latency: req seen at edge k -> gnt valid after edge k+1.
//   - If req==0: stay in IDLE; outputs stay 0 (gnt_idx holds its last value).
//  GRANT: release when any of these holds:
//   (a) done=1
//   (b) req[gnt_idx]=0 (requester dropped)
//   (c) HOLD_MAX!=0 and hold_cnt==HOLD_MAX-1
//  On release:
//   - gnt=0, gnt_valid=0; state=IDLE.
//   - ptr=gnt_idx+1 mod 8 (7 wraps to 0).
//   - hold_cnt=0.
//   - timeout=1 for one cycle, only if (c) applies and neither (a) nor (b) does.
//  Otherwise in GRANT: hold_cnt++, saturating at HOLD_MAX-1.
//  Spacing: at least one IDLE cycle between successive grants, so the minimum
//   grant period is 2 cycles.
//  done while in IDLE: ignored. Changes on other req bits while in GRANT:
//   ignored until release.
//  The granted requester re-requesting: loses priority until all other
//   requesters have been scanned (ptr moved past it).
//  Invariants:
//   - gnt is one-hot or zero.
//   - gnt==(gnt_valid ? 1<<gnt_idx : 0).
//  hold_cnt width: clog2(HOLD_MAX)+1; with HOLD_MAX=1, every grant lasts exactly
//   one cycle and times out unless (a) or (b) applies in that cycle.
// STRUCTURE
//  Package arb_pkg:
//   - state enum (IDLE=1'b0, GRANT=1'b1)
//   - constants N=8, IDXW=3
//  Sub-module prio_enc_8to3, combinational:
//   - in[7:0] -> out[2:0], valid; lowest set bit wins.
//  Top-level datapath:
//   - rotate req right by ptr, encode, then add ptr mod 8 to get the index.
//  All state lives in the top-level: ptr, state, hold_cnt and the output
//   registers.
// TESTING
//  1 Apply rst mid-GRANT (req=8'h04 granted) -> all outputs 0 at once, no edge
//    needed; after reset, ptr=0.
//  2 req=8'hFF held, done pulsed every grant -> gnt_idx cycles 0,1,...,7,0.
//    A grant every 3 cycles when done is pulsed the cycle after the grant.
//  3 ptr=6 (after granting 5), req=8'h21 -> grant idx 0 (wrap, scan 6,7,0).
//    Next grant, with done and req still 8'h21 -> idx 5.
//  4 HOLD_MAX=16, req=8'h08 held, no done -> gnt_valid high 16 cycles.
//    timeout pulses once; one IDLE cycle follows; idx 3 is granted again.
//  5 req=8'h02 granted, then req drops to 8'h00 -> gnt=0 next edge,
//    timeout=0, ptr=2.
//  6 In GRANT, done and hold_cnt==HOLD_MAX-1 in the same cycle -> release with
//    timeout=0. done in IDLE -> no effect.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
// Imported by the arbiter top and its select logic.
package arb_pkg;

    localparam int N        = 8;
    localparam int IDXW     = 3;
    localparam int HOLD_DEF = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/prio_enc_8to3.sv
// Combinational 8-to-3 priority encoder.
// The lowest set bit wins; valid flags a non-zero input.
module prio_enc_8to3 (
    input  logic [7:0] in,
    output logic [2:0] out,
    output logic       valid
);

    always_comb begin
        out   = 3'd0;
        valid = 1'b1;
        priority case (1'b1)
            in[0]:   out = 3'd0;
            in[1]:   out = 3'd1;
            in[2]:   out = 3'd2;
            in[3]:   out = 3'd3;
            in[4]:   out = 3'd4;
            in[5]:   out = 3'd5;
            in[6]:   out = 3'd6;
            in[7]:   out = 3'd7;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with registered grant,
// done/drop release and a hold timeout.
module rr_arbiter_8 #(
    parameter int N        = 8,
    parameter int IDXW     = 3,
    parameter int HOLD_MAX = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            done,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_valid,
    output logic            timeout
);

    import arb_pkg::*;

    if (N != arb_pkg::N || IDXW != arb_pkg::IDXW) begin : g_size_chk
        $error("rr_arbiter_8 supports only N=8, IDXW=3");
    end

    localparam int HCW  = $clog2(HOLD_MAX) + 1;
    localparam int HLIM = (HOLD_MAX == 0) ? 0 : HOLD_MAX - 1;

    localparam logic [HCW-1:0] HOLD_LIM = HCW'(HLIM);

    state_t          state;
    state_t          state_nxt;
    logic [IDXW-1:0] ptr;
    logic [IDXW-1:0] ptr_nxt;
    logic [HCW-1:0]  hold_cnt;
    logic [HCW-1:0]  hold_nxt;
    logic [N-1:0]    gnt_nxt;
    logic [IDXW-1:0] idx_nxt;
    logic            vld_nxt;
    logic            to_nxt;

    logic [2*N-1:0]  req_dbl;
    logic [N-1:0]    req_rot;
    logic [IDXW-1:0] enc_off;
    logic            enc_vld;
    logic [IDXW-1:0] pick_idx;

    logic            rel_done;
    logic            rel_drop;
    logic            rel_to;
    logic            rel;

    // Rotating right by ptr puts requester ptr at bit 0, so the
    // lowest-set-bit encoder scans ptr, ptr+1, ... with wrap.
    assign req_dbl  = {req, req} >> ptr;
    assign req_rot  = req_dbl[N-1:0];
    assign pick_idx = enc_off + ptr;

    prio_enc_8to3 u_enc (
        .in    (req_rot),
        .out   (enc_off),
        .valid (enc_vld)
    );

    assign rel_done = done;
    assign rel_drop = ~req[gnt_idx];
    assign rel_to   = (HOLD_MAX != 0) && (hold_cnt == HOLD_LIM);
    assign rel      = rel_done | rel_drop | rel_to;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (enc_vld) begin
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (rel) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt_nxt  = gnt;
        idx_nxt  = gnt_idx;
        vld_nxt  = gnt_valid;
        to_nxt   = 1'b0;
        ptr_nxt  = ptr;
        hold_nxt = hold_cnt;
        unique case (state)
            IDLE: begin
                gnt_nxt  = '0;
                vld_nxt  = 1'b0;
                hold_nxt = '0;
                if (enc_vld) begin
                    gnt_nxt = N'(1) << pick_idx;
                    idx_nxt = pick_idx;
                    vld_nxt = 1'b1;
                end
            end
            GRANT: begin
                if (rel) begin
                    gnt_nxt  = '0;
                    vld_nxt  = 1'b0;
                    hold_nxt = '0;
                    ptr_nxt  = gnt_idx + IDXW'(1);
                    // Only a pure timeout is flagged; a coincident
                    // done or drop counts as a normal release.
                    to_nxt   = rel_to & ~rel_done & ~rel_drop;
                end else if (hold_cnt != HOLD_LIM) begin
                    hold_nxt = hold_cnt + HCW'(1);
                end
            end
            default: begin
                gnt_nxt = '0;
                vld_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            ptr       <= '0;
            hold_cnt  <= '0;
        end else begin
            gnt       <= gnt_nxt;
            gnt_idx   <= idx_nxt;
            gnt_valid <= vld_nxt;
            timeout   <= to_nxt;
            ptr       <= ptr_nxt;
            hold_cnt  <= hold_nxt;
        end
    end

endmodule
